// File: rtl/rtc_init_sequencer_if.sv
// RTC register-write bus between the init sequencer (master) and the RTC bus driver (slave).
// The master holds wr_req with a stable address and data until the slave pulses wr_ack.
interface rtc_init_sequencer_if;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_data,
        input  wr_ack
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        output wr_ack
    );
endinterface

// File: rtl/rtc_init_sequencer.sv
// RTC init sequencer: walks the init ROM from address 0 and issues one register write per
// entry over a req/ack bus. It stops at the end-marker byte or after the last ROM address.
// A write that waits too long for its ack aborts the run and raises error.
module rtc_init_sequencer #(
    parameter int unsigned ADDR_W     = 4,
    parameter logic [7:0]  BASE_ADDR  = 8'h00,
    parameter logic [7:0]  END_MARKER = 8'hFF,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    output logic [ADDR_W-1:0]          rom_addr_o,
    input  logic [7:0]                 rom_data_i,
    rtc_init_sequencer_if.master       wr_bus,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       error_o,
    output logic [ADDR_W:0]            wr_count_o
);

    // Timeout counter is wide enough to hold TIMEOUT itself.
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW:0] TimeoutVal = (TW + 1)'(TIMEOUT);
    localparam logic [ADDR_W-1:0] LastIdx = '1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StReq,
        StDone,
        StError
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     wr_count_q, wr_count_d;
    logic [TW-1:0]       cnt_q, cnt_d;
    logic                wr_req_q, wr_req_d;
    logic [7:0]          wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic [TW:0]         cnt_inc;
    logic [7:0]          idx_ext;

    assign cnt_inc = {1'b0, cnt_q} + {{TW{1'b0}}, 1'b1};
    assign idx_ext = 8'(idx_q);

    // State and output registers; reset drops wr_req immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            wr_count_q <= '0;
            cnt_q      <= '0;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_count_q <= wr_count_d;
            cnt_q      <= cnt_d;
            wr_req_q   <= wr_req_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Next-state logic: fetch a ROM byte, request its write, advance on ack or abort on timeout.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wr_count_d = wr_count_q;
        cnt_d      = cnt_q;
        wr_req_d   = wr_req_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    idx_d      = '0;
                    wr_count_d = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                if (rom_data_i == END_MARKER) begin
                    state_d = StDone;
                end else begin
                    wr_data_d = rom_data_i;
                    wr_addr_d = BASE_ADDR + idx_ext;
                    wr_req_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = StReq;
                end
            end
            StReq: begin
                cnt_d = cnt_inc[TW-1:0];
                // Ack wins over a timeout landing in the same cycle.
                if (wr_bus.wr_ack) begin
                    wr_req_d   = 1'b0;
                    wr_count_d = wr_count_q + {{ADDR_W{1'b0}}, 1'b1};
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
                        state_d = StFetch;
                    end
                end else if (cnt_inc == TimeoutVal) begin
                    wr_req_d = 1'b0;
                    state_d  = StError;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StError: begin
                // idx is left where the abort happened.
                busy_d  = 1'b0;
                error_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rom_addr_o     = idx_q;
    assign wr_bus.wr_req  = wr_req_q;
    assign wr_bus.wr_addr = wr_addr_q;
    assign wr_bus.wr_data = wr_data_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign wr_count_o     = wr_count_q;

endmodule

// File: tb/tb_rtc_init_sequencer.sv
// Bench for rtc_init_sequencer: a ROM array, an acking bus driver that logs completed writes,
// and a reference model that derives the expected write list straight from the ROM image.
module tb_rtc_init_sequencer;

    localparam int unsigned AW        = 4;
    localparam int unsigned Entries   = 16;
    localparam logic [7:0]  TbBase    = 8'h20;
    localparam int unsigned TbTimeout = 255;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   wr_count;

    logic [7:0]    rom [Entries];

    rtc_init_sequencer_if bus ();

    rtc_init_sequencer #(
        .ADDR_W     (AW),
        .BASE_ADDR  (TbBase),
        .END_MARKER (8'hFF),
        .TIMEOUT    (TbTimeout)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .wr_bus     (bus),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error),
        .wr_count_o (wr_count)
    );

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Bus driver configuration (written by the main sequence only).
    int          ack_delay;
    bit          withhold_en;
    logic [7:0]  withhold_addr;
    bit          stray_ack;

    // Observations (written by the driver only).
    logic [7:0]  obs_addr [$];
    logic [7:0]  obs_data [$];
    int          gaps [$];
    int          hlens [$];

    // Expected results (written by the model only).
    logic [7:0]  exp_addr [$];
    logic [7:0]  exp_data [$];
    bit          exp_err;
    int          exp_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver: acks ack_delay cycles after a request rises, logs each acked write, and records
    // low-gap lengths before every rise and high lengths of every request.
    initial begin
        int age;
        int low_run;
        int high_run;
        bit prev_req;
        age         = 0;
        low_run     = 1000;
        high_run    = 0;
        prev_req    = 1'b0;
        bus.wr_ack  = 1'b0;
        forever begin
            @(negedge clk);
            bus.wr_ack = 1'b0;
            if (bus.wr_req === 1'b1) begin
                if (!prev_req) begin
                    gaps.push_back(low_run);
                    high_run = 0;
                end
                low_run = 0;
                high_run++;
                age++;
                if (age > ack_delay && !(withhold_en && bus.wr_addr == withhold_addr)) begin
                    bus.wr_ack = 1'b1;
                    obs_addr.push_back(bus.wr_addr);
                    obs_data.push_back(bus.wr_data);
                    age = 0;
                end
                prev_req = 1'b1;
            end else begin
                if (prev_req) hlens.push_back(high_run);
                age = 0;
                low_run++;
                if (stray_ack) bus.wr_ack = 1'b1;
                prev_req = 1'b0;
            end
        end
    end

    // Reference: write entries in order up to the first 0xFF or the end of the ROM; a withheld
    // ack aborts at that entry. Final ROM index is where the walk stopped.
    task automatic model();
        logic [7:0] a;
        exp_addr.delete();
        exp_data.delete();
        exp_err = 1'b0;
        exp_idx = Entries - 1;
        for (int i = 0; i < Entries; i++) begin
            if (rom[i] == 8'hFF) begin
                exp_idx = i;
                break;
            end
            a = TbBase + 8'(i);
            if (withhold_en && a == withhold_addr) begin
                exp_err = 1'b1;
                exp_idx = i;
                break;
            end
            exp_addr.push_back(a);
            exp_data.push_back(rom[i]);
        end
    endtask

    task automatic std_rom();
        logic [7:0] img [10];
        img = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF};
        for (int i = 0; i < Entries; i++) rom[i] = (i < 10) ? img[i] : 8'h77;
    endtask

    // One full run from a start pulse; poke re-pulses start mid-run.
    task automatic run_seq(input string tag, input bit poke);
        int ob0;
        int g0;
        int cyc;
        int nobs;
        int rises;
        ob0 = obs_addr.size();
        g0  = gaps.size();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "/busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, "/flags_cleared"}, 32'({done, error}), 32'd0);
        cyc = 0;
        while (!(done === 1'b1 || error === 1'b1) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = poke && (cyc == 10);
        end
        start = 1'b0;
        chk({tag, "/finished_in_time"}, 32'(cyc < 2000), 32'd1);
        @(negedge clk);
        nobs = obs_addr.size() - ob0;
        chk({tag, "/write_count_seen"}, 32'(nobs), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < nobs; i++) begin
            chk($sformatf("%s/addr%0d", tag, i), 32'(obs_addr[ob0 + i]), 32'(exp_addr[i]));
            chk($sformatf("%s/data%0d", tag, i), 32'(obs_data[ob0 + i]), 32'(exp_data[i]));
        end
        chk({tag, "/done"}, 32'(done), 32'(!exp_err));
        chk({tag, "/error"}, 32'(error), 32'(exp_err));
        chk({tag, "/busy_end"}, 32'(busy), 32'd0);
        chk({tag, "/wr_req_end"}, 32'(bus.wr_req), 32'd0);
        chk({tag, "/wr_count"}, 32'(wr_count), 32'(exp_addr.size()));
        chk({tag, "/rom_addr_end"}, 32'(rom_addr), 32'(exp_idx));
        rises = gaps.size() - g0;
        chk({tag, "/req_rises"}, 32'(rises), 32'(exp_addr.size() + int'(exp_err)));
        for (int i = 1; i < rises; i++) begin
            chk($sformatf("%s/gap%0d", tag, i), 32'(gaps[g0 + i]), 32'd1);
        end
        if (exp_err) begin
            chk({tag, "/timeout_len"}, 32'(hlens[hlens.size() - 1]), 32'(TbTimeout));
        end
    endtask

    initial begin
        int cyc;
        int ob0;
        start         = 1'b0;
        ack_delay     = 3;
        withhold_en   = 1'b0;
        withhold_addr = 8'h00;
        stray_ack     = 1'b0;
        std_rom();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/done", 32'(done), 32'd0);
        chk("reset/error", 32'(error), 32'd0);
        chk("reset/wr_count", 32'(wr_count), 32'd0);
        chk("reset/rom_addr", 32'(rom_addr), 32'd0);
        chk("reset/wr_req", 32'(bus.wr_req), 32'd0);
        chk("reset/wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("reset/wr_data", 32'(bus.wr_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Standard image, acks three cycles after each request rises.
        ack_delay = 3;
        model();
        run_seq("std", 1'b0);

        // Stray ack while idle must not change anything.
        ob0 = obs_addr.size();
        @(negedge clk);
        stray_ack = 1'b1;
        repeat (2) @(negedge clk);
        stray_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_ack/wr_count", 32'(wr_count), 32'd9);
        chk("stray_ack/done", 32'(done), 32'd1);
        chk("stray_ack/busy", 32'(busy), 32'd0);
        chk("stray_ack/wr_req", 32'(bus.wr_req), 32'd0);
        chk("stray_ack/no_writes", 32'(obs_addr.size() - ob0), 32'd0);

        // Immediate acks: one dead cycle between requests.
        ack_delay = 0;
        model();
        run_seq("imm_ack", 1'b0);

        // No end marker: all 16 entries written, no address wrap.
        for (int i = 0; i < Entries; i++) rom[i] = 8'h5A;
        ack_delay = 1;
        model();
        run_seq("full_rom", 1'b0);

        // Ack withheld on the third write -> timeout abort.
        std_rom();
        ack_delay     = 2;
        withhold_en   = 1'b1;
        withhold_addr = TbBase + 8'h02;
        model();
        run_seq("timeout", 1'b0);
        withhold_en = 1'b0;

        // Rerun after the abort clears error and starts again from entry 0.
        model();
        run_seq("rerun", 1'b0);

        // Start pulsed while a request is pending is ignored.
        ack_delay = 5;
        model();
        run_seq("start_in_req", 1'b1);

        // End marker in entry 0: no writes, done three edges after start.
        rom[0] = 8'hFF;
        model();
        ob0 = obs_addr.size();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ff_first/busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("ff_first/done_not_yet", 32'(done), 32'd0);
        @(negedge clk);
        chk("ff_first/done", 32'(done), 32'd1);
        chk("ff_first/busy_end", 32'(busy), 32'd0);
        chk("ff_first/wr_count", 32'(wr_count), 32'd0);
        chk("ff_first/no_writes", 32'(obs_addr.size() - ob0), 32'd0);

        // Reset while the fifth request is pending, then a clean full run.
        std_rom();
        ack_delay = 3;
        ob0 = obs_addr.size();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(obs_addr.size() - ob0 == 4 && bus.wr_req === 1'b1) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_reset/reached_5th", 32'(cyc < 500), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset/wr_req", 32'(bus.wr_req), 32'd0);
        chk("mid_reset/busy", 32'(busy), 32'd0);
        chk("mid_reset/wr_count", 32'(wr_count), 32'd0);
        chk("mid_reset/rom_addr", 32'(rom_addr), 32'd0);
        chk("mid_reset/wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("mid_reset/wr_data", 32'(bus.wr_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model();
        run_seq("post_reset", 1'b0);

        // Random ROM images, ack delays and occasional withheld acks.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < Entries; i++) begin
                rom[i] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
            end
            ack_delay     = $urandom_range(0, 4);
            withhold_en   = ($urandom_range(0, 2) == 0);
            withhold_addr = TbBase + 8'($urandom_range(0, 15));
            model();
            run_seq($sformatf("rnd%0d", r), 1'b0);
        end
        withhold_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rtc_init_sequencer.md
Name: rtc_init_sequencer

Overview:
Sequences the RTC initialisation ROM after power-up or on request. It walks the ROM addresses from 0, latches each 8-bit configuration byte and issues one register write per entry to the RTC bus driver over a req/ack handshake. It stops at the end-marker byte or at the last ROM address. It sits between the top-level control FSM and the RTC bus interface, and reports busy, done and a write-timeout error.

Parameters:
ADDR_W, 4, ROM address width; the ROM holds 2**ADDR_W entries.
BASE_ADDR, 8'h00, RTC register address written for ROM entry 0; entry i is written to BASE_ADDR+i (8-bit, wraps modulo 256).
END_MARKER, 8'hFF, ROM byte that terminates the sequence; this byte is never written.
TIMEOUT, 255, maximum cycles wr_req may wait for wr_ack before the sequencer aborts.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse; begins the sequence when idle.
rom_addr  output  ADDR_W  address to the init ROM (combinational ROM).
rom_data  input  8  byte returned by the ROM for rom_addr, valid in the same cycle.
wr_req  output  1  write request to the RTC bus driver, level-held until acked.
wr_addr  output  8  RTC register address; stable while wr_req=1.
wr_data  output  8  RTC register data; stable while wr_req=1.
wr_ack  input  1  one-cycle acknowledge from the bus driver; the write has completed.
busy  output  1  high from the cycle after an accepted start until DONE/ERROR is reached.
done  output  1  level; high after normal completion until the next accepted start.
error  output  1  level; high after a timeout abort until the next accepted start.
wr_count  output  ADDR_W+1  number of writes completed in the current or last run.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rom_addr=0; wr_req=0; wr_addr=0; wr_data=0; busy=0; done=0; error=0; wr_count=0; idx=0; timeout counter=0.
- rom_addr = idx register, driven as a registered value.
- States: IDLE, FETCH, REQ, DONE, ERROR.
- IDLE: a start sampled high causes these actions on the next edge:
  - idx:=0, wr_count:=0, done:=0, error:=0, busy:=1, go to FETCH.
- FETCH (1 cycle):
  - If rom_data==END_MARKER, go to DONE.
  - Otherwise latch wr_data:=rom_data and wr_addr:=BASE_ADDR+idx, set wr_req:=1, clear the timeout counter, and go to REQ.
- REQ: wr_req, wr_addr and wr_data are held constant. The timeout counter increments each cycle.
  - If wr_ack=1: wr_req:=0 and wr_count+1.
    - If idx==2**ADDR_W-1, go to DONE (no address wrap).
    - Otherwise idx+1 and go to FETCH.
  - Else, if the counter reaches TIMEOUT: wr_req:=0, go to ERROR.
  - wr_ack takes priority over timeout in the same cycle.
- DONE: busy:=0, done:=1, return to IDLE (done stays high).
- ERROR: busy:=0, error:=1, return to IDLE (error stays high); idx is frozen for debug.
- Latency: start at edge N gives FETCH at N+1 and wr_req=1 from N+2. An ack at edge M gives the next wr_req=1 from M+2, i.e. one dead cycle between writes.
- start while busy=1 is ignored, including in FETCH and REQ.
- wr_ack while wr_req=0 is ignored.
- If the first ROM entry is END_MARKER: zero writes; done=1 three cycles after start.
- Reset mid-transfer: wr_req drops immediately (asynchronously); the RTC driver must tolerate an aborted request.
- Widths: wr_count is wide enough for 2**ADDR_W writes; BASE_ADDR+idx is truncated to 8 bits.

Test Plan:
- Standard ROM image (00,00,00,00,01,01,00,00,00,FF), BASE_ADDR=0, bus driver acks 3 cycles after each wr_req rise → exactly 9 writes to addresses 0x00..0x08, data 0x01 at addresses 0x04 and 0x05, all others 0x00. Final state: done=1, wr_count=9, busy=0, no access with data 0xFF.
- BASE_ADDR=8'h20 with the same image and immediate acks → write addresses 0x20..0x28; consecutive wr_req pulses separated by exactly one low cycle.
- ROM with no 0xFF entry (all 16 entries 0x5A) → 16 writes at idx 0..15, then done=1 and wr_count=16; rom_addr never wraps to 0 during the run.
- Ack withheld on the 3rd write, TIMEOUT=255 → wr_req drops after 255 REQ cycles, error=1, done=0, wr_count=2. A subsequent start clears error and reruns from address 0.
- start pulsed during REQ and wr_ack pulsed while idle → both ignored: no restart, and no change to wr_count or state.
- rst_n asserted low while wr_req=1 on the 5th write → all outputs return to reset values asynchronously. A start after release performs the full 9-write sequence.
